// File: rtl/retire_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : retire_perf_monitor
// Description : Retire-stream performance monitor. It counts cycles,
//               retired instructions, control transfers, mispredictions and
//               bubble cycles. It detects a "j ." self-loop as program end,
//               and returns any counter through a registered read port.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W        width of every event counter (8..32)
//   HALT_REPEAT  consecutive same-PC retires that declare halt (>=2)
// Ports
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_clear      synchronous clear of counters/state (single-cycle pulse)
//   i_insn_vld   an instruction retires this cycle
//   i_pc_debug   PC of the retiring instruction
//   i_ctrl       retiring instruction is a branch/jump
//   i_mispred    retiring control transfer was mispredicted
//   i_sel        read select: 0 cyc, 1 ret, 2 ctl, 3 mis, 4 bub,
//                5 last_pc, 6 state, 7 zero
//   o_rdata      registered read data, zero-extended from CNT_W
//   o_halt       sticky halt-detected flag
//   o_ovf        sticky counter-overflow flag
// Configuration
//   PERF_CNT_SAT_EN  defined  : counters saturate at all-ones
//                    undefined: counters wrap to zero
// ============================================================================
module retire_perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int HALT_REPEAT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_insn_vld,
  input  logic [31:0] i_pc_debug,
  input  logic        i_ctrl,
  input  logic        i_mispred,
  input  logic [2:0]  i_sel,
  output logic [31:0] o_rdata,
  output logic        o_halt,
  output logic        o_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int              NCNT    = 5;  // 0 cyc, 1 ret, 2 ctl, 3 mis, 4 bub
  localparam int              REP_W   = $clog2(HALT_REPEAT + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(HALT_REPEAT);

  state_t                       state_q, state_d;
  logic [NCNT-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]                  last_pc_q, last_pc_d;
  logic [REP_W-1:0]             rep_q, rep_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic                         halt_q, halt_d;
  logic                         ovf_q, ovf_d;
  logic                         count_en;
  logic [NCNT-1:0]              inc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_pc_d = last_pc_q;
    rep_d     = rep_q;
    ovf_d     = ovf_q;
    rdata_d   = '0;

    // Counting happens in RUN and on the IDLE->RUN transition cycle only.
    count_en = (state_q == ST_RUN) || ((state_q == ST_IDLE) && i_insn_vld);

    inc[0] = 1'b1;
    inc[1] = i_insn_vld;
    inc[2] = i_insn_vld & i_ctrl;
    inc[3] = i_insn_vld & i_ctrl & i_mispred;
    inc[4] = ~i_insn_vld;

    // Read mux samples the pre-edge counter values.
    case (i_sel)
      3'd0:    rdata_d = 32'(cnt_q[0]);
      3'd1:    rdata_d = 32'(cnt_q[1]);
      3'd2:    rdata_d = 32'(cnt_q[2]);
      3'd3:    rdata_d = 32'(cnt_q[3]);
      3'd4:    rdata_d = 32'(cnt_q[4]);
      3'd5:    rdata_d = last_pc_q;
      3'd6:    rdata_d = {30'd0, state_q};
      default: rdata_d = '0;
    endcase

    if (count_en) begin
      for (int i = 0; i < NCNT; i++) begin
        if (inc[i]) begin
          if (&cnt_q[i]) begin
            ovf_d = 1'b1;
`ifdef PERF_CNT_SAT_EN
            cnt_d[i] = cnt_q[i];
`else
            cnt_d[i] = '0;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end

      if (state_q == ST_IDLE) begin
        state_d = ST_RUN;
      end

      if (i_insn_vld) begin
        // The first retire after reset/clear always reloads, even at PC 0.
        if ((state_q == ST_IDLE) || (i_pc_debug != last_pc_q)) begin
          last_pc_d = i_pc_debug;
          rep_d     = REP_W'(1);
        end else if (rep_q != REP_MAX) begin
          rep_d = rep_q + REP_W'(1);
        end
        if (rep_d == REP_MAX) begin
          state_d = ST_HALTED;
        end
      end
    end

    halt_d = (state_d == ST_HALTED);

    if (i_clear) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      last_pc_d = '0;
      rep_d     = '0;
      ovf_d     = 1'b0;
      halt_d    = 1'b0;
      rdata_d   = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_pc_q <= '0;
      rep_q     <= '0;
      rdata_q   <= '0;
      halt_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_pc_q <= last_pc_d;
      rep_q     <= rep_d;
      rdata_q   <= rdata_d;
      halt_q    <= halt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_rdata = rdata_q;
  assign o_halt  = halt_q;
  assign o_ovf   = ovf_q;

endmodule
`default_nettype wire
